// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/interlock controller for the F/D/X/M/W pipeline. Tracks pending
//   register writers in a shifting scoreboard (entry0=X, entry1=M, entry2=W),
//   raises RAW interlocks, handles taken-branch redirect/flush, and can
//   insert a periodic stall to emulate memory latency (STALL_PERIOD >= 2).
//   Optional feature macro: PIPE_HAZARD_FWD_EN
//     defined   -> operand forwarding; only load-use on entry0 interlocks,
//                  fwd_a_sel/fwd_b_sel report the bypass source for X.
//     undefined -> any pending writer interlocks; forward selects are 00.
module pipe_hazard_ctrl #(
  parameter int RA_W         = 5,
  parameter int PC_W         = 32,
  parameter int SB_DEPTH     = 3,
  parameter int STALL_PERIOD = 0,
  parameter int PERF_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [RA_W-1:0]   d_rs,
  input  logic [RA_W-1:0]   d_rt,
  input  logic              d_rs_used,
  input  logic              d_rt_used,
  input  logic [RA_W-1:0]   d_dst,
  input  logic              d_rwe,
  input  logic              d_is_load,
  input  logic              x_do_branch,
  input  logic [PC_W-1:0]   x_pc_effective,
  output logic              stall_fd,
  output logic              bubble_dx,
  output logic              flush_fd,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            is_load;
  } sb_entry_t;

  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;

  logic                rs_in_use, rt_in_use;
  logic [SB_DEPTH-1:0] rs_hit, rt_hit;
  logic                raw_hazard;
  logic                pstall;
  logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

  // r0 is hard-wired to zero, so reading it can never depend on a writer.
  assign rs_in_use = d_rs_used && (d_rs != '0);
  assign rt_in_use = d_rt_used && (d_rt != '0);

  // Compare each in-use source against every pending destination.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first,
    // so no path through the block leaves it unassigned and infers a latch.
    rs_hit = '0;
    rt_hit = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      rs_hit[i] = rs_in_use && sb_q[i].valid && (sb_q[i].dst == d_rs);
      rt_hit[i] = rt_in_use && sb_q[i].valid && (sb_q[i].dst == d_rt);
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  // With bypassing only a load still in X cannot supply its data in time.
  assign raw_hazard = (rs_hit[0] || rt_hit[0]) && sb_q[0].is_load;
`else
  // Without bypassing the reader waits until the writer has left W.
  assign raw_hazard = (|rs_hit) || (|rt_hit);
`endif

  // Pipeline controls: redirect beats interlock; everything is quiet in reset.
  always_comb begin
    stall_fd  = 1'b0;
    bubble_dx = 1'b0;
    flush_fd  = 1'b0;
    redirect  = 1'b0;
    if (!reset) begin
      if (x_do_branch) begin
        redirect  = 1'b1;
        flush_fd  = 1'b1;
        bubble_dx = 1'b1;
      end else if ((raw_hazard || pstall) && d_valid) begin
        stall_fd  = 1'b1;
        bubble_dx = 1'b1;
      end
    end
  end

  assign redirect_pc = x_pc_effective;

  // Next scoreboard: shift toward W, enter the decoding writer unless it is held or killed.
  always_comb begin
    sb_d = '0;
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    sb_d[0].valid   = d_valid && d_rwe && (d_dst != '0) && !stall_fd && !flush_fd && !bubble_dx;
    sb_d[0].dst     = d_dst;
    sb_d[0].is_load = d_is_load;
  end

  // Scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the scoreboard is control state, not a data array: it must come
    // out of reset all-invalid or phantom writers would stall the first reads.
    if (reset) begin
      sb_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      sb_q <= sb_d;
    end
  end

  generate
    if (STALL_PERIOD >= 2) begin : g_pstall
      localparam int CNT_W = $clog2(STALL_PERIOD);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);
      logic [CNT_W-1:0] per_cnt_q, per_cnt_d;

      // Free-running modulo-P counter; it keeps advancing through stalls.
      always_comb begin
        per_cnt_d = (per_cnt_q == CNT_LAST) ? '0 : per_cnt_q + CNT_W'(1);
      end

      // Period counter register.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          per_cnt_q <= '0;
        end else begin
          per_cnt_q <= per_cnt_d;
        end
      end

      assign pstall = (per_cnt_q == CNT_LAST);
    end else begin : g_no_pstall
      assign pstall = 1'b0;
    end
  endgenerate

`ifdef PIPE_HAZARD_FWD_EN
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_XM = 2'b01,
    FWD_MW = 2'b10
  } fwd_sel_e;

  fwd_sel_e fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Youngest matching writer wins; entry2 and older have already written the regfile.
  function automatic fwd_sel_e fwd_code(input logic [SB_DEPTH-1:0] hit);
    if (hit[0]) return FWD_XM;
    if (hit[1]) return FWD_MW;
    return FWD_RF;
  endfunction

  // Capture the selects as the instruction moves D->X; hold while decode is stalled.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!stall_fd) begin
      if (bubble_dx || !d_valid) begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        fwd_a_d = fwd_code(rs_hit);
        fwd_b_d = fwd_code(rt_hit);
      end
    end
  end

  // Forward-select registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  // Not every scoreboard field or hit bit is consumed in each configuration.
  logic unused_sb;
  assign unused_sb = ^{sb_q, rs_hit, rt_hit};

  // Saturating count of stalled decode cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // Stall performance counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. dut_a has no periodic stall;
//   dut_p uses STALL_PERIOD=4 with a 2-bit counter so saturation is reachable.
//   Expectations follow PIPE_HAZARD_FWD_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        d_valid, d_rs_used, d_rt_used, d_rwe, d_is_load, x_do_branch;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [31:0] x_pc_effective;

  logic        a_stall, a_bubble, a_flush, a_redirect;
  logic [31:0] a_redirect_pc;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_cycles;

  logic        p_stall, p_bubble, p_flush, p_redirect;
  logic [31:0] p_redirect_pc;
  logic [1:0]  p_fwd_a, p_fwd_b;
  logic [1:0]  p_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl dut_a (
    .clock(clock), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_dst(d_dst), .d_rwe(d_rwe), .d_is_load(d_is_load),
    .x_do_branch(x_do_branch), .x_pc_effective(x_pc_effective),
    .stall_fd(a_stall), .bubble_dx(a_bubble), .flush_fd(a_flush),
    .redirect(a_redirect), .redirect_pc(a_redirect_pc),
    .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b), .stall_cycles(a_cycles)
  );

  pipe_hazard_ctrl #(.STALL_PERIOD(4), .PERF_W(2)) dut_p (
    .clock(clock), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_dst(d_dst), .d_rwe(d_rwe), .d_is_load(d_is_load),
    .x_do_branch(x_do_branch), .x_pc_effective(x_pc_effective),
    .stall_fd(p_stall), .bubble_dx(p_bubble), .flush_fd(p_flush),
    .redirect(p_redirect), .redirect_pc(p_redirect_pc),
    .fwd_a_sel(p_fwd_a), .fwd_b_sel(p_fwd_b), .stall_cycles(p_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_rs_used = 1'b0; d_rt_used = 1'b0;
    d_dst = '0; d_rwe = 1'b0; d_is_load = 1'b0;
    x_do_branch = 1'b0; x_pc_effective = '0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                           input logic rtu, input logic [4:0] dst, input logic rwe,
                           input logic ld);
    d_valid = 1'b1; d_rs = rs; d_rt = rt; d_rs_used = rsu; d_rt_used = rtu;
    d_dst = dst; d_rwe = rwe; d_is_load = ld;
    x_do_branch = 1'b0; x_pc_effective = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    set_nop();
    repeat (3) tick();
  endtask

  initial begin
    set_nop();
    x_do_branch = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    // Reset state: registered outputs cleared, controls quiet even with a branch pending.
    check("rst_stall", a_stall, 0);
    check("rst_redirect", a_redirect, 0);
    check("rst_flush", a_flush, 0);
    check("rst_cycles", a_cycles, 0);
    check("rst_fwd_a", a_fwd_a, 0);
    set_nop();
    reset = 1'b0;
    tick();

    // 1: addu r3,r1,r2 ; addu r4,r3,r3
    set_instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    #1 check("t1_first_stall", a_stall, 0);
    tick();
    set_instr(5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
`ifdef PIPE_HAZARD_FWD_EN
    #1 check("t1_dep_stall", a_stall, 0);
    tick();
    set_nop();
    #1 check("t1_fwd_a", a_fwd_a, 2'b01);
    check("t1_fwd_b", a_fwd_b, 2'b01);
    check("t1_cycles", a_cycles, 0);
`else
    #1 check("t1_stall_c1", a_stall, 1);
    check("t1_bubble_c1", a_bubble, 1);
    check("t1_flush_c1", a_flush, 0);
    tick();
    #1 check("t1_stall_c2", a_stall, 1);
    tick();
    #1 check("t1_stall_c3", a_stall, 1);
    tick();
    #1 check("t1_stall_c4", a_stall, 0);
    check("t1_cycles", a_cycles, 3);
    tick();
    set_nop();
    #1 check("t1_fwd_a", a_fwd_a, 0);
`endif
    drain();

    // 2: lw r5,0(r29) ; addu r6,r5,r0
    set_instr(5'd29, 5'd5, 1, 0, 5'd5, 1, 1);
    #1 check("t2_lw_stall", a_stall, 0);
    tick();
    set_instr(5'd5, 5'd0, 1, 1, 5'd6, 1, 0);
    #1 check("t2_use_stall", a_stall, 1);
    check("t2_use_bubble", a_bubble, 1);
    tick();
`ifdef PIPE_HAZARD_FWD_EN
    #1 check("t2_use_stall2", a_stall, 0);
    tick();
    set_nop();
    #1 check("t2_fwd_a", a_fwd_a, 2'b10);
    check("t2_fwd_b", a_fwd_b, 2'b00);
`else
    #1 check("t2_use_stall2", a_stall, 1);
    tick();
    #1 check("t2_use_stall3", a_stall, 1);
    tick();
    #1 check("t2_use_stall4", a_stall, 0);
    tick();
`endif
    #0 check("t2_cycles", a_cycles, FWD ? 1 : 6);
    drain();

    // 3: r3 hazard pending while a taken branch resolves.
    set_instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    tick();
    set_instr(5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
    x_do_branch = 1'b1;
    x_pc_effective = 32'h8002_0040;
    #1 check("t3_redirect", a_redirect, 1);
    check("t3_redirect_pc", a_redirect_pc, 32'h8002_0040);
    check("t3_flush", a_flush, 1);
    check("t3_bubble", a_bubble, 1);
    check("t3_stall", a_stall, 0);
    tick();
    set_nop();
    #1 check("t3_redirect_off", a_redirect, 0);
    check("t3_flush_off", a_flush, 0);
    check("t3_fwd_a_cleared", a_fwd_a, 0);
    check("t3_cycles", a_cycles, FWD ? 1 : 6);
    drain();

    // 4: r0 writes never create hazards; unused sources never match.
    set_instr(5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
    tick();
    set_instr(5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
    #1 check("t4_r0_stall", a_stall, 0);
    tick();
    set_nop();
    #1 check("t4_r0_fwd_a", a_fwd_a, 0);
    check("t4_r0_fwd_b", a_fwd_b, 0);
    tick();
    set_instr(5'd1, 5'd2, 1, 1, 5'd8, 1, 0);
    tick();
    set_instr(5'd8, 5'd9, 0, 1, 5'd12, 1, 0);
    #1 check("t4_unused_rs", a_stall, 0);
    tick();
    set_instr(5'd1, 5'd8, 0, 1, 5'd13, 1, 0);
    #1 check("t4_rt_m_stage", a_stall, FWD ? 0 : 1);
    tick();
    set_nop();
    #1 check("t4_rt_fwd_b", a_fwd_b, FWD ? 2 : 0);
    drain();

    // 6: reset during a load-use stall, then a fresh dependent pair.
    set_instr(5'd29, 5'd9, 1, 0, 5'd9, 1, 1);
    tick();
    set_instr(5'd9, 5'd9, 1, 1, 5'd14, 1, 0);
    #1 check("t6_pre_stall", a_stall, 1);
    reset = 1'b1;
    #1 check("t6_rst_stall", a_stall, 0);
    check("t6_rst_bubble", a_bubble, 0);
    check("t6_rst_cycles", a_cycles, 0);
    check("t6_rst_fwd_a", a_fwd_a, 0);
    tick();
    reset = 1'b0;
    #1 check("t6_empty_sb", a_stall, 0);
    tick();
    set_instr(5'd29, 5'd10, 1, 0, 5'd10, 1, 1);
    tick();
    set_instr(5'd10, 5'd1, 1, 1, 5'd15, 1, 0);
    #1 check("t6_restall", a_stall, 1);
    tick();
    #1 check("t6_restall2", a_stall, FWD ? 0 : 1);
    tick();
    set_nop();
    #1 check("t6_cycles", a_cycles, FWD ? 1 : 2);
    drain();

    // 5: periodic stall on dut_p with independent instructions.
    reset = 1'b1;
    tick();
    set_instr(5'd1, 5'd2, 1, 1, 5'd0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 17; c++) begin
      #1;
      check($sformatf("t5_pstall_c%0d", c), p_stall, (c % 4 == 3) ? 1 : 0);
      check($sformatf("t5_pbubble_c%0d", c), p_bubble, (c % 4 == 3) ? 1 : 0);
      check($sformatf("t5_nostall_c%0d", c), a_stall, 0);
      if (c == 12) check("t5_cycles_c12", p_cycles, 3);
      if (c == 16) check("t5_cycles_sat", p_cycles, 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
